rr_arb_mux: RTL
===============

// Module: rr_arb_mux
// PURPOSE
//   Registered M-channel, N-bit round-robin arbitrating multiplexer with valid/ready handshake.
//   Parametrised successor of the combinational 8:1 mux: the select is generated internally
//   by a fair arbiter, not driven externally, and the result is held in an output register
//   with backpressure. Used to merge several producer streams onto one datapath consumer.
// PARAMETERS
//   N     32  data width per channel
//   M     8   number of input channels, 2..2**SELW; need not be a power of two
//   SELW  3   width of channel index; must satisfy M <= 2**SELW
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   M      per-channel request; bit i = channel i holds a word
//   in_data    in   M*N    flattened inputs; channel i = in_data[i*N +: N]
//   in_ready   out  M      per-channel accept; at most one bit set per cycle
//   out_valid  out  1      out_data/out_sel hold a word
//   out_ready  in   1      consumer accepts the word this cycle
//   out_data   out  N      registered selected word
//   out_sel    out  SELW   index of the channel that supplied out_data
//   in_last    in   M      (ARB_LOCK_EN only) bit i marks channel i's word as end of packet
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_sel=0, in_ready=0, priority pointer ptr=0, lock cleared.
//   load = !out_valid | out_ready  (output register empty or being drained this cycle).
//   Arbitration (combinational): first i with in_valid[i]=1, scanning ptr, ptr+1, ..., M-1, 0, ...
//     ptr-1. Scan wraps at M-1 -> 0; indices >= M never granted. Result: grant g, hit flag.
//   in_ready = load & hit ? onehot(g) : 0. in_ready may depend on in_valid in the same cycle.
//   On edge with load & hit: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=(g==M-1)?0:g+1.
//   On edge with load & !hit: out_valid<=0; out_data/out_sel/ptr hold.
//   On edge with !load: all output state holds (stall); in_ready=0 for all channels.
//   Latency 1 cycle from in handshake to out_valid; sustained throughput 1 word/cycle with
//   out_ready held high (drain and refill in the same cycle).
//   Fairness: a continuously valid channel is granted within M accepted words.
//   in_valid deasserting without in_ready: word not taken; no state change for that channel.
//   Reset mid-operation: held word discarded, out_valid=0 next cycle, ptr=0, lock cleared.
// CONFIGURATION
//   ARB_LOCK_EN defined: in_last port present; FSM states ARB (default) and LOCK.
//     ARB: grant as above. If granted word has in_last[g]=0 -> LOCK, lock_ch<=g, ptr holds.
//       If in_last[g]=1 -> stay ARB, ptr<=g+1 mod M.
//     LOCK: only lock_ch eligible (hit = in_valid[lock_ch]); other channels starve.
//       Accepted word with in_last=1 -> ARB, ptr<=lock_ch+1 mod M; with in_last=0 -> stay LOCK.
//     Reset forces ARB from either state.
//   ARB_LOCK_EN undefined: no in_last port, no FSM; every word re-arbitrates (per-word RR).
// TESTING
//   1 Reset: assert reset 2 cycles with all in_valid=1 -> out_valid=0, in_ready=0, out_sel=0.
//   2 All 8 valid, data i=32'hA0+i, out_ready=1 -> out_sel 0,1,..,7,0 on consecutive cycles,
//     out_data 32'hA0..32'hA7, one in_ready bit per cycle.
//   3 Backpressure: in_valid=8'h10, out_ready=0 after first word -> out_valid=1, out_data held
//     stable, in_ready=0 until out_ready=1; then next word taken same cycle.
//   4 Wrap with M=5: in_valid=5'b10001, ptr after grant 4 -> next grant 0, out_sel never >4.
//   5 Sparse: only ch3 valid, then only ch1 -> grants 3 then 1 (ptr=4 wraps to 1), no idle gap.
//   6 ARB_LOCK_EN: ch2 sends 3 beats in_last=0,0,1 while ch0,ch5 valid -> out_sel 2,2,2,5,0;
//     reset during beat 2 -> out_valid=0, next grant from ptr=0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating M:1 multiplexer with a registered, backpressured output stage.
// Define ARB_LOCK_EN to add in_last and hold the grant on one channel until its packet ends.
module rr_arb_mux #(
  parameter int N    = 32,
  parameter int M    = 8,
  parameter int SELW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [M-1:0]      in_valid,
  input  logic [M*N-1:0]    in_data,
`ifdef ARB_LOCK_EN
  input  logic [M-1:0]      in_last,
`endif
  output logic [M-1:0]      in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [SELW-1:0]   out_sel
);

  logic              out_valid_q;
  logic [N-1:0]      data_q;
  logic [SELW-1:0]   sel_q;
  logic [SELW-1:0]   ptr_q;
  logic [SELW-1:0]   ptr_d;
  logic [M-1:0]      elig;
  logic              hit;
  logic              load;
  logic [SELW-1:0]   grant;
  logic [N-1:0]      ch_data [M];

`ifdef ARB_LOCK_EN
  typedef enum logic {ST_ARB, ST_LOCK} state_t;
  state_t            state_q;
  logic [SELW-1:0]   lock_ch_q;
  logic              locked;
  assign locked = (state_q == ST_LOCK);
`endif

  assign load = !out_valid_q || out_ready;

  for (genvar gi = 0; gi < M; gi++) begin : g_ch
    assign ch_data[gi] = in_data[gi*N +: N];
`ifdef ARB_LOCK_EN
    // While locked, only the owning channel may compete.
    assign elig[gi] = in_valid[gi] && (!locked || lock_ch_q == SELW'(gi));
`else
    assign elig[gi] = in_valid[gi];
`endif
    assign in_ready[gi] = !reset && load && hit && (grant == SELW'(gi));
  end

  // Scan from the highest rotated offset down so the closest request to ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    hit   = 1'b0;
    grant = '0;
    for (int k = M - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= M) idx = idx - M;
      if (elig[idx]) begin
        hit   = 1'b1;
        grant = SELW'(idx);
      end
    end
  end

  assign ptr_d = (grant == SELW'(M - 1)) ? '0 : grant + SELW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
`ifdef ARB_LOCK_EN
      state_q     <= ST_ARB;
      lock_ch_q   <= '0;
`endif
    end else if (load) begin
      if (hit) begin
        out_valid_q <= 1'b1;
        data_q      <= ch_data[grant];
        sel_q       <= grant;
`ifdef ARB_LOCK_EN
        case (state_q)
          ST_ARB: begin
            if (in_last[grant]) begin
              ptr_q <= ptr_d;
            end else begin
              state_q   <= ST_LOCK;
              lock_ch_q <= grant;
            end
          end
          default: begin
            if (in_last[grant]) begin
              state_q <= ST_ARB;
              ptr_q   <= ptr_d;
            end
          end
        endcase
`else
        ptr_q <= ptr_d;
`endif
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
